// File: rtl/vga_sync_lock.sv
// vga_sync_lock: recovers hsync/vsync timing, locks onto a stable stream and regenerates pixel position and data enable
module vga_sync_lock #(
  parameter int H_START     = 61,
  parameter int H_ACTIVE    = 640,
  parameter int V_START     = 16,
  parameter int V_ACTIVE    = 587,
  parameter int TOL         = 2,
  parameter int LOCK_FRAMES = 4
) (
  input  logic        clk24,
  input  logic        reset_n,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic        locked,
  output logic [10:0] hperiod,
  output logic [10:0] hwidth,
  output logic [9:0]  vlines,
  output logic [9:0]  xpos,
  output logic [9:0]  ypos,
  output logic        de
);
  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;
  localparam logic [10:0] HS   = 11'(H_START);
  localparam logic [10:0] HE   = 11'(H_START + H_ACTIVE);
  localparam logic [10:0] TOLW = 11'(TOL);
  localparam logic [9:0]  VS   = 10'(V_START);
  localparam logic [9:0]  VE   = 10'(V_START + V_ACTIVE);
  localparam logic [7:0]  LAST = 8'(LOCK_FRAMES - 1);
  state_t state, state_n;
  logic [2:0] hs, vs;
  logic [10:0] hcnt, hnext, hact, refper;
  logic [9:0] lcnt, vact, refframe;
  logic [7:0] good;
  logic cap, fresh, bad, hf, hr, vf, vr, hsat, per_bad, frame_bad, mark, frame_good, win, show;
  function automatic logic [10:0] adiff(input logic [10:0] a, input logic [10:0] b);
    return a > b ? a - b : b - a;
  endfunction
  assign hf         = hs[2] & ~hs[1];
  assign hr         = ~hs[2] & hs[1];
  assign vf         = vs[2] & ~vs[1];
  assign vr         = ~vs[2] & vs[1];
  assign hsat       = &hcnt;
  assign hnext      = hsat ? hcnt : hcnt + 11'd1;
  assign per_bad    = adiff(hnext, refper) > TOLW;
  assign frame_bad  = adiff({1'b0, lcnt}, {1'b0, refframe}) > TOLW;
  assign mark       = hf & ~cap & per_bad;
  assign frame_good = ~fresh & ~bad & ~mark & ~frame_bad;
  assign win        = hact >= HS && hact < HE && vact >= VS && vact < VE;
  assign show       = state_n == LOCKED && win;
  assign locked     = state == LOCKED;
  // two synchronizer flops then one edge-detect flop per sync input
  always_ff @(posedge clk24 or negedge reset_n)
    if (!reset_n) begin
      hs <= '0;
      vs <= '0;
    end else begin
      hs <= {hs[1:0], hsync_in};
      vs <= {vs[1:0], vsync_in};
    end
  // line period, sync width, frame length and window position counters; all saturate
  always_ff @(posedge clk24 or negedge reset_n)
    if (!reset_n) begin
      hcnt    <= '0;
      lcnt    <= '0;
      hact    <= '0;
      vact    <= '0;
      hperiod <= '0;
      hwidth  <= '0;
      vlines  <= '0;
    end else begin
      hcnt    <= hf ? '0 : hnext;
      hperiod <= hf ? hnext : hperiod;
      hwidth  <= hr ? hnext : hwidth;
      lcnt    <= vf ? '0 : (hf && ~&lcnt) ? lcnt + 10'd1 : lcnt;
      vlines  <= vf ? lcnt : vlines;
      hact    <= hr ? 11'd1 : &hact ? hact : hact + 11'd1;
      vact    <= vr ? '0 : (hr && ~&vact) ? vact + 10'd1 : vact;
    end
  // reference period/frame tracking and consecutive good-frame count
  always_ff @(posedge clk24 or negedge reset_n)
    if (!reset_n) begin
      refper   <= '0;
      refframe <= '0;
      good     <= '0;
      cap      <= 1'b0;
      fresh    <= 1'b0;
      bad      <= 1'b0;
    end else if (state == SEARCH) begin
      if (vf) begin
        good  <= '0;
        cap   <= 1'b1;
        fresh <= 1'b1;
        bad   <= 1'b0;
      end
    end else begin
      if (hf && cap) begin
        refper <= hnext;
        cap    <= 1'b0;
      end
      if (mark) bad <= 1'b1;
      if (vf) begin
        refframe <= lcnt;
        fresh    <= 1'b0;
        bad      <= 1'b0;
        if (!fresh) good <= frame_good ? good + 8'd1 : '0;
        if (!fresh && !frame_good) refper <= hperiod;
      end
    end
  // lock state register
  always_ff @(posedge clk24 or negedge reset_n)
    if (!reset_n) state <= SEARCH;
    else state <= state_n;
  // lock state transitions; a saturated line counter always forces a fresh search
  always_comb begin
    state_n = state;
    if (state == SEARCH && vf) state_n = ACQUIRE;
    if (state == ACQUIRE && vf && frame_good && good == LAST) state_n = LOCKED;
    if (state == LOCKED && ((hf && per_bad) || (vf && frame_bad))) state_n = SEARCH;
    if (hsat) state_n = SEARCH;
  end
  // registered data enable and positions, dropping together with locked
  always_ff @(posedge clk24 or negedge reset_n)
    if (!reset_n) begin
      de   <= 1'b0;
      xpos <= '0;
      ypos <= '0;
    end else begin
      de   <= show;
      xpos <= show ? 10'(hact - HS) : '0;
      ypos <= show ? vact - VS : '0;
    end
endmodule
